// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared definitions for the elevator car controller:
//   - AC motion-command encodings (code 3 is handled like AC_STOP)
//   - number of floors served
//   - car state enum
//   - floor_onehot(): floor number -> one-hot at-floor sensor vector
package elevator_pkg;

  localparam logic [1:0] AC_UP   = 2'd0;
  localparam logic [1:0] AC_DOWN = 2'd1;
  localparam logic [1:0] AC_STOP = 2'd2;

  localparam logic [2:0] N_FLOORS = 3'd4;

  typedef enum logic [2:0] {
    AT_FLOOR     = 3'd0,
    TRAVEL_UP    = 3'd1,
    TRAVEL_DOWN  = 3'd2,
    DOOR_OPENING = 3'd3,
    DOOR_OPEN    = 3'd4,
    DOOR_CLOSING = 3'd5
  } car_state_t;

  // Bit 0 is floor 1. An out-of-range floor gives all zeros.
  function automatic logic [3:0] floor_onehot(input logic [2:0] floor_num);
    logic [3:0] oh;
    oh = 4'b0000;
    case (floor_num)
      3'd1:    oh = 4'b0001;
      3'd2:    oh = 4'b0010;
      3'd3:    oh = 4'b0100;
      3'd4:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/seg_timer.sv
// seg_timer
// Loadable down-counter shared by the travel and door phases of car_drive.
// Ports:
//   CLK    in   clock, rising edge
//   RESET  in   synchronous active-high reset, clears the count
//   load   in   load the count from value at the next edge
//   value  in   W-bit reload value (phase length minus one)
//   done   out  count reads zero
// Once the count reaches zero it holds there until the next load.
module seg_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/car_drive.sv
// car_drive
// Elevator car drive controller for a four-floor shaft: moves the car one
// floor segment at a time on AC commands and sequences the door on OPEN.
// The travel and door phases share one seg_timer.
//
// Parameters:
//   FLOOR_TICKS  cycles per floor segment (2..255)
//   DOOR_TICKS   cycles per door open or close stroke (2..255)
//   INIT_FLOOR   floor occupied after reset (1..4)
// Ports:
//   CLK          in   clock, rising edge
//   RESET        in   synchronous active-high reset, overrides everything
//   AC[1:0]      in   motion command: 0 up, 1 down, 2/3 stop
//   OPEN         in   door-open request, level-sensitive
//   S1..S4       out  at-floor sensors, one-hot at a floor, zero in travel
//   POS[2:0]     out  last floor reached
//   MOVING       out  car is in a travel state
//   DOOR         out  door fully open
//   FAULT        out  sticky illegal-command flag
// Build option:
//   CAR_DRIVE_FAULT_EN  when defined, an up/down command that cannot be
//                       obeyed sets FAULT until RESET; otherwise FAULT is 0
//                       and such commands are simply ignored.
//
// State table:
//   AT_FLOOR     | parked at POS, door closed, accepting commands
//   TRAVEL_UP    | moving towards POS+1, commands ignored
//   TRAVEL_DOWN  | moving towards POS-1, commands ignored
//   DOOR_OPENING | door stroke opening
//   DOOR_OPEN    | door fully open, held while OPEN is high
//   DOOR_CLOSING | door stroke closing, OPEN re-opens
module car_drive
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4,
  parameter int INIT_FLOOR  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] AC,
  input  logic       OPEN,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic [2:0] POS,
  output logic       MOVING,
  output logic       DOOR,
  output logic       FAULT
);

  localparam logic [7:0] FLOOR_LOAD = 8'(FLOOR_TICKS - 1);
  localparam logic [7:0] DOOR_LOAD  = 8'(DOOR_TICKS - 1);
  localparam logic [2:0] POS_RESET  = 3'(INIT_FLOOR);

  car_state_t state, next_state;
  logic [2:0] pos, pos_next;
  logic       timer_load;
  logic [7:0] timer_value;
  logic       timer_done;
  logic       traveling;
  logic [3:0] sensors;

  seg_timer #(.W(8)) u_seg_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= AT_FLOOR;
      pos   <= POS_RESET;
    end else begin
      state <= next_state;
      pos   <= pos_next;
    end
  end

  always_comb begin
    next_state  = state;
    pos_next    = pos;
    timer_load  = 1'b0;
    timer_value = DOOR_LOAD;
    case (state)
      AT_FLOOR: begin
        if (OPEN) begin
          next_state  = DOOR_OPENING;
          timer_load  = 1'b1;
          timer_value = DOOR_LOAD;
        end else begin
          case (AC)
            AC_UP: begin
              if (pos < N_FLOORS) begin
                next_state  = TRAVEL_UP;
                timer_load  = 1'b1;
                timer_value = FLOOR_LOAD;
              end
            end
            AC_DOWN: begin
              if (pos > 3'd1) begin
                next_state  = TRAVEL_DOWN;
                timer_load  = 1'b1;
                timer_value = FLOOR_LOAD;
              end
            end
            AC_STOP: next_state = AT_FLOOR;
            default: next_state = AT_FLOOR;
          endcase
        end
      end
      TRAVEL_UP: begin
        if (timer_done) begin
          pos_next   = pos + 3'd1;
          next_state = AT_FLOOR;
        end
      end
      TRAVEL_DOWN: begin
        if (timer_done) begin
          pos_next   = pos - 3'd1;
          next_state = AT_FLOOR;
        end
      end
      DOOR_OPENING: begin
        if (timer_done) next_state = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        if (!OPEN) begin
          next_state  = DOOR_CLOSING;
          timer_load  = 1'b1;
          timer_value = DOOR_LOAD;
        end
      end
      DOOR_CLOSING: begin
        // A re-open request wins over stroke completion and restarts the
        // opening stroke from the beginning.
        if (OPEN) begin
          next_state  = DOOR_OPENING;
          timer_load  = 1'b1;
          timer_value = DOOR_LOAD;
        end else if (timer_done) begin
          next_state = AT_FLOOR;
        end
      end
      default: next_state = AT_FLOOR;
    endcase
  end

  assign traveling = (state == TRAVEL_UP) || (state == TRAVEL_DOWN);

  always_comb begin
    sensors = floor_onehot(pos);
    if (traveling) sensors = 4'b0000;
  end

  assign {S4, S3, S2, S1} = sensors;
  assign POS    = pos;
  assign MOVING = traveling;
  assign DOOR   = (state == DOOR_OPEN);

`ifdef CAR_DRIVE_FAULT_EN
  logic illegal_cmd;
  logic fault_q;

  // Up at the top floor, down at the bottom floor, or any motion command
  // while the door is in use.
  always_comb begin
    illegal_cmd = 1'b0;
    case (state)
      AT_FLOOR: illegal_cmd = ((AC == AC_UP) && (pos == N_FLOORS)) ||
                              ((AC == AC_DOWN) && (pos == 3'd1));
      DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING:
        illegal_cmd = (AC == AC_UP) || (AC == AC_DOWN);
      default: illegal_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fault_q <= 1'b0;
    end else if (illegal_cmd) begin
      fault_q <= 1'b1;
    end
  end

  assign FAULT = fault_q;
`else
  assign FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_car_drive.sv
// tb_car_drive
// Directed stimulus for car_drive (FLOOR_TICKS=8, DOOR_TICKS=4, INIT_FLOOR=1).
// The driver queues expected output snapshots tagged with the clock edge
// count they apply to; a monitor compares them at the following falling edge.
module tb_car_drive;
  import elevator_pkg::*;

`ifdef CAR_DRIVE_FAULT_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] AC;
  logic       OPEN;
  logic       S1, S2, S3, S4;
  logic [2:0] POS;
  logic       MOVING, DOOR, FAULT;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [9:0] v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  car_drive #(
    .FLOOR_TICKS (8),
    .DOOR_TICKS  (4),
    .INIT_FLOOR  (1)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .AC     (AC),
    .OPEN   (OPEN),
    .S1     (S1),
    .S2     (S2),
    .S3     (S3),
    .S4     (S4),
    .POS    (POS),
    .MOVING (MOVING),
    .DOOR   (DOOR),
    .FAULT  (FAULT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [3:0] s, input logic [2:0] p,
                           input logic m, input logic d, input logic f,
                           input string nm);
    exp_t e;
    e.cyc = c;
    e.v   = {s, p, m, d, f};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    string      nm;
    logic [9:0] act;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {S4, S3, S2, S1, POS, MOVING, DOOR, FAULT};
        n_tests++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: checked at edge %0d, required at edge %0d", nm, cyc, e.cyc);
        end else if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got S4..S1=%b POS=%0d MOVING=%b DOOR=%b FAULT=%b, want S4..S1=%b POS=%0d MOVING=%b DOOR=%b FAULT=%b",
                   nm, cyc, act[9:6], act[5:3], act[2], act[1], act[0],
                   e.v[9:6], e.v[5:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    int t;
    RESET = 1'b1;
    AC    = AC_STOP;
    OPEN  = 1'b0;
    expect_at(2, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "reset_state");
    wait_cyc(3);

    // AC=0 held from floor 1: climb to floor 4 and stay there.
    t = cyc;
    expect_at(t+1,  4'b0000, 3'd1, 1'b1, 1'b0, 1'b0, "depart_f1");
    expect_at(t+8,  4'b0000, 3'd1, 1'b1, 1'b0, 1'b0, "seg1_last");
    expect_at(t+9,  4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "arrive_f2");
    expect_at(t+10, 4'b0000, 3'd2, 1'b1, 1'b0, 1'b0, "depart_f2");
    expect_at(t+18, 4'b0100, 3'd3, 1'b0, 1'b0, 1'b0, "arrive_f3");
    expect_at(t+27, 4'b1000, 3'd4, 1'b0, 1'b0, 1'b0, "arrive_f4");
    expect_at(t+28, 4'b1000, 3'd4, 1'b0, 1'b0, FE,   "stay_f4");
    expect_at(t+35, 4'b1000, 3'd4, 1'b0, 1'b0, FE,   "stay_f4_late");
    RESET = 1'b0;
    AC    = AC_UP;
    wait_cyc(t+35);

    // Reset at floor 4, then a one-cycle AC=0 pulse: one full segment.
    t = cyc;
    expect_at(t+1,  4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "reset_from_f4");
    expect_at(t+2,  4'b0000, 3'd1, 1'b1, 1'b0, 1'b0, "pulse_depart");
    expect_at(t+9,  4'b0000, 3'd1, 1'b1, 1'b0, 1'b0, "pulse_no_stop");
    expect_at(t+10, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "pulse_arrive");
    expect_at(t+14, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "pulse_stay");
    RESET = 1'b1;
    AC    = AC_STOP;
    wait_cyc(t+1);
    RESET = 1'b0;
    AC    = AC_UP;
    wait_cyc(t+2);
    AC = AC_STOP;
    wait_cyc(t+14);

    // Door cycle at floor 2 with OPEN held for 10 cycles, then go down.
    t = cyc;
    expect_at(t+1,  4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "opening_start");
    expect_at(t+4,  4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "opening_last");
    expect_at(t+5,  4'b0010, 3'd2, 1'b0, 1'b1, 1'b0, "door_open");
    expect_at(t+10, 4'b0010, 3'd2, 1'b0, 1'b1, 1'b0, "door_hold");
    expect_at(t+11, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "closing_start");
    expect_at(t+14, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "closing_last");
    expect_at(t+15, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, "closed_at_f2");
    expect_at(t+16, 4'b0000, 3'd2, 1'b1, 1'b0, 1'b0, "depart_down");
    expect_at(t+24, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "arrive_f1_down");
    OPEN = 1'b1;
    wait_cyc(t+10);
    OPEN = 1'b0;
    wait_cyc(t+15);
    AC = AC_DOWN;
    wait_cyc(t+16);
    AC = AC_STOP;
    wait_cyc(t+24);

    // Re-open during the second closing cycle at floor 1.
    t = cyc;
    expect_at(t+5,  4'b0001, 3'd1, 1'b0, 1'b1, 1'b0, "f1_door_open");
    expect_at(t+7,  4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "f1_closing");
    expect_at(t+8,  4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "f1_closing2");
    expect_at(t+12, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "reopening_last");
    expect_at(t+13, 4'b0001, 3'd1, 1'b0, 1'b1, 1'b0, "reopened");
    expect_at(t+14, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "reclosing");
    OPEN = 1'b1;
    wait_cyc(t+6);
    OPEN = 1'b0;
    wait_cyc(t+8);
    OPEN = 1'b1;
    wait_cyc(t+9);
    OPEN = 1'b0;
    wait_cyc(t+18);

    // AC=1 at floor 1 for 5 cycles: no motion.
    t = cyc;
    for (int i = 1; i <= 5; i++)
      expect_at(t+i, 4'b0001, 3'd1, 1'b0, 1'b0, FE, $sformatf("down_at_f1_%0d", i));
    expect_at(t+8, 4'b0001, 3'd1, 1'b0, 1'b0, FE, "down_at_f1_after");
    AC = AC_DOWN;
    wait_cyc(t+5);
    AC = AC_STOP;
    wait_cyc(t+8);

    // Reset in the middle of the floor 2 -> 3 segment, AC=0 still applied.
    t = cyc;
    expect_at(t+9,  4'b0010, 3'd2, 1'b0, 1'b0, FE,   "mid_arrive_f2");
    expect_at(t+14, 4'b0000, 3'd2, 1'b1, 1'b0, FE,   "mid_travel");
    expect_at(t+15, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "mid_reset");
    expect_at(t+16, 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, "after_reset");
    AC = AC_UP;
    wait_cyc(t+14);
    RESET = 1'b1;
    wait_cyc(t+15);
    RESET = 1'b0;
    AC    = AC_STOP;
    wait_cyc(t+16);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/car_drive.md
CAR_DRIVE -- requirements
Module: car_drive

Interface
REQ-001 Parameter FLOOR_TICKS, default 8, cycles to travel one floor segment (legal range 2..255).
REQ-002 Parameter DOOR_TICKS, default 4, cycles for a full door open or close stroke (legal range 2..255).
REQ-003 Parameter INIT_FLOOR, default 1, floor (1..4) the car occupies after reset.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 AC  input  2  motion command: 0 up, 1 down, 2 stop, 3 treated as stop.
REQ-007 OPEN  input  1  door-open request, level-sensitive.
REQ-008 S1, S2, S3, S4  output  1 each  at-floor sensors, one-hot while at a floor, all 0 between floors.
REQ-009 POS  output  3  last floor reached, 1..4.
REQ-010 MOVING  output  1  high while in a travel state.
REQ-011 DOOR  output  1  high only while the door is fully open.
REQ-012 FAULT  output  1  sticky illegal-command flag.

Function
REQ-013 The block SHALL be a 6-state FSM: AT_FLOOR, TRAVEL_UP, TRAVEL_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING.
REQ-014 In AT_FLOOR, priority SHALL be OPEN first, then AC; OPEN=1 -> DOOR_OPENING; AC=0 with POS<4 -> TRAVEL_UP; AC=1 with POS>1 -> TRAVEL_DOWN; otherwise stay.
REQ-015 On entering a travel state, the segment counter SHALL load FLOOR_TICKS-1, all S outputs SHALL be 0 and MOVING SHALL be 1 from the same edge.
REQ-016 The counter SHALL decrement once per cycle; at the edge where it reads 0, POS SHALL step by +1 (up) or -1 (down) and the state SHALL return to AT_FLOOR, so arrival comes FLOOR_TICKS edges after departure.
REQ-017 AC and OPEN SHALL be ignored during travel: no mid-segment reversal or stop.
REQ-018 The car SHALL spend at least one cycle in AT_FLOOR with the matching S output high before it departs again.
REQ-019 DOOR_OPENING and DOOR_CLOSING SHALL each last DOOR_TICKS cycles, using the same counter loaded to DOOR_TICKS-1.
REQ-020 DOOR_OPEN SHALL hold while OPEN=1; OPEN=0 -> DOOR_CLOSING.
REQ-021 OPEN=1 during DOOR_CLOSING SHALL return the FSM to DOOR_OPENING with a full reload.
REQ-022 S outputs SHALL stay asserted for POS in all door states.
REQ-023 Illegal-command conditions SHALL be: AC=0 at POS=4 in AT_FLOOR; AC=1 at POS=1 in AT_FLOOR; AC=0 or AC=1 in any door state. Each SHALL cause no motion.

Reset
REQ-024 RESET=1 at an edge SHALL force, from any state including mid-travel or mid-door stroke: AT_FLOOR, POS=INIT_FLOOR, the matching S high, MOVING=0, DOOR=0, FAULT=0, counter=0.
REQ-025 RESET SHALL take priority over all other inputs.

Configuration
REQ-026 With macro CAR_DRIVE_FAULT_EN defined, any illegal condition (REQ-023) SHALL set FAULT on the next edge, and FAULT SHALL stay set until RESET.
REQ-027 Without CAR_DRIVE_FAULT_EN, FAULT SHALL be tied to 0 and illegal commands SHALL be silently ignored; all other behaviour SHALL be identical.

Structure
REQ-028 The shared package elevator_pkg SHALL hold the AC encodings (AC_UP=0, AC_DOWN=1, AC_STOP=2), N_FLOORS=4, and the car state enum.
REQ-029 The loadable down-counter with a done flag SHALL be the single sub-module seg_timer (load, value, done), shared by the travel and door phases.

Verification (FLOOR_TICKS=8, DOOR_TICKS=4, INIT_FLOOR=1)
REQ-030 Reset, then AC=0 held: S1 drops at the departure edge; S2 high 8 edges later for at least 1 cycle; S4 high and POS=4 by edge 24 plus per-floor dwell; car then stays at 4; FAULT=1 if the macro is on.
REQ-031 At floor 2, OPEN=1 for 10 cycles then 0: DOOR=1 4 edges after OPEN rises; DOOR=0 the cycle OPEN falls; AT_FLOOR 4 edges later; S2 high throughout.
REQ-032 OPEN pulses 1 at closing cycle 2: FSM returns to DOOR_OPENING; DOOR=1 4 edges later.
REQ-033 AC=0 for 1 cycle then AC=2 from floor 1: car still arrives at floor 2 at edge 8 and stays; MOVING=0 afterwards.
REQ-034 RESET=1 at travel cycle 5 between floors 2 and 3: next edge gives S1=1, POS=1, MOVING=0, FAULT=0.
REQ-035 Macro off, AC=1 at floor 1 for 5 cycles: FAULT stays 0, S1 stays 1, no motion.
